// File: rtl/decay_scheduler.sv
// Shares one potential-decay unit across NUM_NEURONS neurons: on each timestep it walks
// the neurons in address order, issuing operands, waiting for the result and writing it back.
module decay_scheduler #(
   parameter int unsigned NUM_NEURONS = 4,
   parameter int unsigned ADDR_W      = 2,
   parameter logic [31:0] RESET_POT   = 32'h41DED852,
   parameter logic [3:0]  RESET_RATE  = 4'b0001,
   parameter int unsigned TIMEOUT     = 15
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              timestep,
   input  logic              cfg_we,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [31:0]       cfg_potential,
   input  logic [3:0]        cfg_rate,
   input  logic              acc_we,
   input  logic [ADDR_W-1:0] acc_addr,
   input  logic [31:0]       acc_potential,
   input  logic              err_clr,
   output logic              dec_start,
   output logic [ADDR_W-1:0] dec_addr,
   output logic [31:0]       dec_potential,
   output logic [3:0]        dec_rate,
   input  logic              dec_valid,
   input  logic [31:0]       dec_result,
   output logic              wb_valid,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [31:0]       wb_potential,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [31:0]       rd_potential,
   output logic              busy,
   output logic              done,
   output logic              overrun,
   output logic              timeout_err
);

   typedef enum logic [2:0] {StIdle, StIssue, StWait, StWrite, StDone} state_e;

   localparam logic [ADDR_W-1:0] LastIdx    = ADDR_W'(NUM_NEURONS - 1);
   localparam logic [7:0]        TimeoutCnt = 8'(TIMEOUT);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [31:0]         cap_q, cap_d;
   logic                timeout_hit;
   logic [31:0]         pot_q  [NUM_NEURONS];
   logic [3:0]          rate_q [NUM_NEURONS];
   logic [ADDR_W-1:0]   hold_addr_q;
   logic [31:0]         hold_pot_q;
   logic [3:0]          hold_rate_q;
   logic                overrun_q;
   logic                timeout_q;
   logic [31:0]         rd_q;

   // Unsupported rate codes fall back to the slowest decay.
   function automatic logic [3:0] legal_rate(input logic [3:0] r);
      case (r)
         4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011: return r;
         default:                                     return 4'b0001;
      endcase
   endfunction

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      cap_d       = cap_q;
      timeout_hit = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (timestep) begin
               idx_d   = '0;
               state_d = StIssue;
            end
         end
         StIssue: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            if (dec_valid) begin
               cap_d   = dec_result;
               state_d = StWrite;
            end else if (cnt_q == TimeoutCnt) begin
               cap_d       = pot_q[idx_q];
               timeout_hit = 1'b1;
               state_d     = StWrite;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StWrite: begin
            if (idx_q == LastIdx) begin
               state_d = StDone;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = StIssue;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         cnt_q       <= '0;
         cap_q       <= '0;
         hold_addr_q <= '0;
         hold_pot_q  <= '0;
         hold_rate_q <= '0;
         overrun_q   <= 1'b0;
         timeout_q   <= 1'b0;
         rd_q        <= '0;
         for (int a = 0; a < NUM_NEURONS; a++) begin
            pot_q[a]  <= RESET_POT;
            rate_q[a] <= RESET_RATE;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         cap_q   <= cap_d;
         rd_q    <= pot_q[rd_addr];
         if (state_q == StIssue) begin
            hold_addr_q <= idx_q;
            hold_pot_q  <= pot_q[idx_q];
            hold_rate_q <= rate_q[idx_q];
         end
         if (timestep && state_q != StIdle) overrun_q <= 1'b1;
         else if (err_clr)                  overrun_q <= 1'b0;
         if (timeout_hit)  timeout_q <= 1'b1;
         else if (err_clr) timeout_q <= 1'b0;
         // Per-address priority: config, then write-back, then potential adder.
         for (int a = 0; a < NUM_NEURONS; a++) begin
            if (cfg_we && cfg_addr == ADDR_W'(a)) begin
               pot_q[a]  <= cfg_potential;
               rate_q[a] <= legal_rate(cfg_rate);
            end else if (state_q == StWrite && idx_q == ADDR_W'(a)) begin
               pot_q[a] <= cap_q;
            end else if (acc_we && acc_addr == ADDR_W'(a)) begin
               pot_q[a] <= acc_potential;
            end
         end
      end
   end

   // Operands come straight from storage in ISSUE and are then held through WAIT.
   assign dec_start     = (state_q == StIssue);
   assign dec_addr      = dec_start ? idx_q : hold_addr_q;
   assign dec_potential = dec_start ? pot_q[idx_q] : hold_pot_q;
   assign dec_rate      = dec_start ? rate_q[idx_q] : hold_rate_q;
   assign wb_valid      = (state_q == StWrite);
   assign wb_addr       = wb_valid ? idx_q : '0;
   assign wb_potential  = wb_valid ? cap_q : '0;
   assign rd_potential  = rd_q;
   assign busy          = (state_q != StIdle);
   assign done          = (state_q == StDone);
   assign overrun       = overrun_q;
   assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_decay_scheduler.sv
// Directed bench for decay_scheduler: per-cycle pass table, rate-legalisation table and
// hand-written sequences for timeout, write priority, overrun and mid-pass reset.
module tb_decay_scheduler;

   localparam logic [31:0] RP = 32'h41DED852;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        timestep = 1'b0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_addr = '0;
   logic [31:0] cfg_potential = '0;
   logic [3:0]  cfg_rate = '0;
   logic        acc_we = 1'b0;
   logic [1:0]  acc_addr = '0;
   logic [31:0] acc_potential = '0;
   logic        err_clr = 1'b0;
   logic        dec_start;
   logic [1:0]  dec_addr;
   logic [31:0] dec_potential;
   logic [3:0]  dec_rate;
   logic        dec_valid = 1'b0;
   logic [31:0] dec_result = '0;
   logic        wb_valid;
   logic [1:0]  wb_addr;
   logic [31:0] wb_potential;
   logic [1:0]  rd_addr = '0;
   logic [31:0] rd_potential;
   logic        busy, done, overrun, timeout_err;

   int errors = 0;
   int checks = 0;

   logic [3:0]  silent = '0;
   logic        fire;
   logic [31:0] res;
   logic [31:0] wb_seen   [4];
   logic [3:0]  rate_seen [4];
   int          wait_cnt;
   int          cyc;

   decay_scheduler dut (
      .CLK           (CLK),
      .RST_N         (RST_N),
      .timestep      (timestep),
      .cfg_we        (cfg_we),
      .cfg_addr      (cfg_addr),
      .cfg_potential (cfg_potential),
      .cfg_rate      (cfg_rate),
      .acc_we        (acc_we),
      .acc_addr      (acc_addr),
      .acc_potential (acc_potential),
      .err_clr       (err_clr),
      .dec_start     (dec_start),
      .dec_addr      (dec_addr),
      .dec_potential (dec_potential),
      .dec_rate      (dec_rate),
      .dec_valid     (dec_valid),
      .dec_result    (dec_result),
      .wb_valid      (wb_valid),
      .wb_addr       (wb_addr),
      .wb_potential  (wb_potential),
      .rd_addr       (rd_addr),
      .rd_potential  (rd_potential),
      .busy          (busy),
      .done          (done),
      .overrun       (overrun),
      .timeout_err   (timeout_err)
   );

   always #5 CLK = ~CLK;

   // Decay unit model: 1-cycle latency; rate 0010 halves (exponent - 1), else identity.
   function automatic logic [31:0] decay_model(input logic [31:0] p, input logic [3:0] r);
      return (r == 4'b0010) ? p - 32'h00800000 : p;
   endfunction

   always @(posedge CLK) begin
      fire = dec_start && !silent[dec_addr];
      res  = decay_model(dec_potential, dec_rate);
      #1;
      dec_valid  = fire;
      dec_result = fire ? res : 32'h0;
   end

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      timestep = 1'b0; cfg_we = 1'b0; acc_we = 1'b0; err_clr = 1'b0; silent = '0;
      step();
      step();
      RST_N = 1'b1;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [31:0] p, input logic [3:0] r);
      cfg_we = 1'b1; cfg_addr = a; cfg_potential = p; cfg_rate = r;
      step();
      cfg_we = 1'b0;
   endtask

   // Pulses timestep and follows the pass until done; cyc is the cycle done is seen.
   task automatic run_pass();
      for (int i = 0; i < 4; i++) begin
         wb_seen[i]   = '0;
         rate_seen[i] = 4'hF;
      end
      wait_cnt = 0;
      timestep = 1'b1;
      step();
      timestep = 1'b0;
      cyc = 1;
      while (cyc < 200) begin
         if (dec_start) rate_seen[dec_addr] = dec_rate;
         if (wb_valid) wb_seen[wb_addr] = wb_potential;
         if (busy && !dec_start && !wb_valid && !done) wait_cnt++;
         if (done) break;
         step();
         cyc++;
      end
      check("pass_reaches_done", {31'd0, done}, 32'd1);
   endtask

   typedef struct {
      logic        busy;
      logic        done;
      logic        ds;
      logic        wbv;
      logic [1:0]  wba;
      logic [31:0] wbp;
   } pass_vec_t;

   typedef struct {
      logic [3:0] cfg;
      logic [3:0] exp;
   } rate_vec_t;

   pass_vec_t ptab [14];
   rate_vec_t rtab [7];

   initial begin
      // Cycle-by-cycle expectations for a plain pass (index i is cycle i+1).
      ptab[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0};
      ptab[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0};
      ptab[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, RP};
      ptab[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0};
      ptab[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0};
      ptab[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, RP};
      ptab[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0};
      ptab[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0};
      ptab[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, RP};
      ptab[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0};
      ptab[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0};
      ptab[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd3, RP};
      ptab[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0};
      ptab[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0};

      rtab[0] = '{4'b0101, 4'b0001};
      rtab[1] = '{4'b0010, 4'b0010};
      rtab[2] = '{4'b0011, 4'b0011};
      rtab[3] = '{4'b0000, 4'b0001};
      rtab[4] = '{4'b1000, 4'b1000};
      rtab[5] = '{4'b1111, 4'b0001};
      rtab[6] = '{4'b0100, 4'b0100};

      // Reset state
      do_reset();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
      check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
      check("rst_dec_start", {31'd0, dec_start}, 32'd0);
      check("rst_dec_potential", dec_potential, 32'd0);
      check("rst_dec_rate", {28'd0, dec_rate}, 32'd0);
      check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("rst_wb_potential", wb_potential, 32'd0);
      check("rst_rd_potential", rd_potential, 32'd0);

      // Plain pass, compared cycle by cycle
      timestep = 1'b1;
      step();
      timestep = 1'b0;
      for (int i = 0; i < 14; i++) begin
         check($sformatf("c%0d_busy", i + 1), {31'd0, busy}, {31'd0, ptab[i].busy});
         check($sformatf("c%0d_done", i + 1), {31'd0, done}, {31'd0, ptab[i].done});
         check($sformatf("c%0d_dec_start", i + 1), {31'd0, dec_start}, {31'd0, ptab[i].ds});
         check($sformatf("c%0d_wb_valid", i + 1), {31'd0, wb_valid}, {31'd0, ptab[i].wbv});
         if (ptab[i].wbv) begin
            check($sformatf("c%0d_wb_addr", i + 1), {30'd0, wb_addr}, {30'd0, ptab[i].wba});
            check($sformatf("c%0d_wb_potential", i + 1), wb_potential, ptab[i].wbp);
         end
         step();
      end

      // Halving rate on neuron 2
      cfg_write(2'd2, RP, 4'b0010);
      run_pass();
      check("halve_done_cycle", cyc, 13);
      check("halve_wb0", wb_seen[0], RP);
      check("halve_wb1", wb_seen[1], RP);
      check("halve_wb2", wb_seen[2], 32'h415ED852);
      check("halve_wb3", wb_seen[3], RP);
      step();
      rd_addr = 2'd2;
      step();
      check("halve_rd2", rd_potential, 32'h415ED852);
      rd_addr = 2'd1;
      step();
      check("halve_rd1", rd_potential, RP);

      // Rate legalisation, observed on dec_rate at neuron 1's next ISSUE
      for (int i = 0; i < 7; i++) begin
         cfg_write(2'd1, RP, rtab[i].cfg);
         run_pass();
         check($sformatf("rate_%b", rtab[i].cfg), {28'd0, rate_seen[1]}, {28'd0, rtab[i].exp});
         step();
      end

      // Write priority in the addr-0 WRITE cycle, plus read-during-write
      do_reset();
      timestep = 1'b1;
      step();
      timestep = 1'b0;
      step();
      step();
      check("prio_wb_valid_c3", {31'd0, wb_valid}, 32'd1);
      acc_we = 1'b1; acc_addr = 2'd0; acc_potential = 32'h40000000;
      cfg_we = 1'b1; cfg_addr = 2'd3; cfg_potential = 32'h3F800000; cfg_rate = 4'b0001;
      rd_addr = 2'd3;
      step();
      acc_we = 1'b0; cfg_we = 1'b0;
      check("prio_rd3_old", rd_potential, RP);
      rd_addr = 2'd0;
      step();
      check("prio_pot0_wb_wins", rd_potential, RP);
      rd_addr = 2'd3;
      step();
      check("prio_pot3_cfg", rd_potential, 32'h3F800000);
      for (int i = 0; i < 40 && !done; i++) step();
      check("prio_pass_done", {31'd0, done}, 32'd1);
      step();

      // Silent decay unit for neuron 1
      do_reset();
      silent = 4'b0010;
      run_pass();
      check("to_done_cycle", cyc, 28);
      check("to_wait_cycles", wait_cnt, 19);
      check("to_wb1", wb_seen[1], RP);
      check("to_wb2", wb_seen[2], RP);
      check("to_flag", {31'd0, timeout_err}, 32'd1);
      check("to_no_overrun", {31'd0, overrun}, 32'd0);
      silent = '0;
      step();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("to_cleared", {31'd0, timeout_err}, 32'd0);

      // Overrun, then reset mid-pass
      do_reset();
      acc_we = 1'b1; acc_addr = 2'd0; acc_potential = 32'h12345678;
      step();
      acc_we = 1'b0;
      timestep = 1'b1;
      step();
      timestep = 1'b0;
      for (int i = 0; i < 5; i++) step();
      check("ovr_c6_wb1", {31'd0, wb_valid}, 32'd1);
      timestep = 1'b1;
      step();
      timestep = 1'b0;
      check("ovr_flag", {31'd0, overrun}, 32'd1);
      check("ovr_no_done", {31'd0, done}, 32'd0);
      RST_N = 1'b0;
      step();
      RST_N = 1'b1;
      check("ovr_rst_busy", {31'd0, busy}, 32'd0);
      check("ovr_rst_overrun", {31'd0, overrun}, 32'd0);
      check("ovr_rst_rd", rd_potential, 32'd0);
      rd_addr = 2'd0;
      step();
      check("ovr_rst_pot0", rd_potential, RP);
      check("ovr_idle", {31'd0, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule
